// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: RV32 size codes, FSM states
// and the request legality helper used by the lane formatter.
package mem_resp_pkg;

    localparam int LAT_W = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Unsigned sizes only exist for loads; stores with LBU/LHU codes are illegal.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core's memory port (master)
// and the data memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_lane_fmt.sv
// Combinational RV32 byte-lane formatting for stores (byte enables + replicated
// data) and loads (lane extract + extension). MISALIGN_TRAP_EN flags misaligned H/W.
module mem_lane_fmt
    import mem_resp_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        fmt_err
);

    function automatic logic [35:0] store_fmt(input logic [2:0]  sz,
                                              input logic [1:0]  ln,
                                              input logic [31:0] wd);
        logic [3:0]  be_v;
        logic [31:0] word_v;
        be_v   = '0;
        word_v = '0;
        case (sz)
            SZ_B: begin
                be_v   = 4'b0001 << ln;
                word_v = {4{wd[7:0]}};
            end
            SZ_H: begin
                be_v   = ln[1] ? 4'b1100 : 4'b0011;
                word_v = {2{wd[15:0]}};
            end
            SZ_W: begin
                be_v   = 4'b1111;
                word_v = wd;
            end
            default: ;
        endcase
        return {be_v, word_v};
    endfunction

    // Halfword selection ignores addr[0] so unaligned halves fall back to their half.
    function automatic logic [31:0] load_fmt(input logic [2:0]  sz,
                                             input logic [1:0]  ln,
                                             input logic [31:0] rw);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rw[{ln, 3'b000} +: 8];
        half_v = ln[1] ? rw[31:16] : rw[15:0];
        case (sz)
            SZ_B:    return {{24{byte_v[7]}}, byte_v};
            SZ_BU:   return {24'd0, byte_v};
            SZ_H:    return {{16{half_v[15]}}, half_v};
            SZ_HU:   return {16'd0, half_v};
            SZ_W:    return rw;
            default: return '0;
        endcase
    endfunction

    logic misalign;

    always_comb begin
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((size == SZ_H || size == SZ_HU) && lane[0])
            misalign = 1'b1;
        if (size == SZ_W && lane != 2'b00)
            misalign = 1'b1;
`endif
    end

    always_comb begin
        {be, wword} = store_fmt(size, lane, wdata);
        rdata       = load_fmt(size, lane, raw);
        fmt_err     = !size_legal(size, we) || misalign;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states, RV32
// lane formatting and a held response. Optional MISALIGN_TRAP_EN traps misaligned H/W.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int          ADDR_W     = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

    state_t             state;
    logic [LAT_W-1:0]   wait_cnt;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [2:0]         cap_size;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        ram [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic               in_range;
    logic               access_err;
    logic               ram_we;
    logic [31:0]        raw_word;
    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        load_data;
    logic               fmt_err;

    assign word_idx   = cap_addr[ADDR_W+1:2];
    assign in_range   = {1'b0, cap_addr} < ADDR_LIMIT;
    assign access_err = !in_range || fmt_err;
    assign ram_we     = (state == ACCESS) && cap_we && !access_err;
    assign raw_word   = ram[word_idx];

    mem_lane_fmt u_lane_fmt (
        .size    (cap_size),
        .lane    (cap_addr[1:0]),
        .we      (cap_we),
        .wdata   (cap_wdata),
        .raw     (raw_word),
        .be      (be),
        .wword   (wword),
        .rdata   (load_data),
        .fmt_err (fmt_err)
    );

    // RAM is deliberately not reset; a store only lands during ACCESS.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    ram[word_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_size    <= SZ_B;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        cap_we      <= bus.req_we;
                        cap_addr    <= bus.req_addr;
                        cap_wdata   <= bus.req_wdata;
                        cap_size    <= bus.req_size;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= LAT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= ACCESS;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                ACCESS: begin
                    rsp_rdata_q <= (access_err || cap_we) ? 32'd0 : load_data;
                    rsp_err_q   <= access_err;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // IDLE is re-entered only after the handshake, so no accept overlaps it.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 0/1/4) against a byte-array
// reference model, directed scenarios plus randomized traffic.
module tb_data_mem_responder;
    import mem_resp_pkg::*;

    localparam int DEPTH = 64;
    localparam int LIMIT = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_size = SZ_W;
    logic        rsp_ready = 1'b0;

    logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
    logic [31:0] cur_rsp_rdata;

    int          check_count = 0;
    int          error_count = 0;
    logic [7:0]  mb [3][LIMIT];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    data_mem_responder_if bus0();
    data_mem_responder_if bus1();
    data_mem_responder_if bus2();

    assign bus0.req_valid = req_valid && (sel == 0);
    assign bus1.req_valid = req_valid && (sel == 1);
    assign bus2.req_valid = req_valid && (sel == 2);
    assign bus0.rsp_ready = rsp_ready && (sel == 0);
    assign bus1.rsp_ready = rsp_ready && (sel == 1);
    assign bus2.rsp_ready = rsp_ready && (sel == 2);
    assign bus0.req_we = req_we;    assign bus1.req_we = req_we;    assign bus2.req_we = req_we;
    assign bus0.req_addr = req_addr;  assign bus1.req_addr = req_addr;  assign bus2.req_addr = req_addr;
    assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata;
    assign bus0.req_size = req_size;  assign bus1.req_size = req_size;  assign bus2.req_size = req_size;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        case (sel)
            0: begin cur_req_ready = bus0.req_ready; cur_rsp_valid = bus0.rsp_valid;
                     cur_rsp_rdata = bus0.rsp_rdata; cur_rsp_err = bus0.rsp_err; end
            1: begin cur_req_ready = bus1.req_ready; cur_rsp_valid = bus1.rsp_valid;
                     cur_rsp_rdata = bus1.rsp_rdata; cur_rsp_err = bus1.rsp_err; end
            default: begin cur_req_ready = bus2.req_ready; cur_rsp_valid = bus2.rsp_valid;
                     cur_rsp_rdata = bus2.rsp_rdata; cur_rsp_err = bus2.rsp_err; end
        endcase
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (dut %0d, t=%0t)", tag, act, exp, sel, $time);
        end
    endtask

    // Reference: memory is a flat byte array; an access is n little-endian bytes.
    task automatic modelAccess(input int s, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] size,
                               output logic [31:0] rdata, output logic err);
        int n, base;
        bit sgn, legal;
        logic [31:0] v;
        rdata = '0; err = 1'b0; n = 1; sgn = 0; legal = 1;
        case (size)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: begin n = 4; end
            3'd4: begin n = 1; legal = !we; end
            3'd5: begin n = 2; legal = !we; end
            default: legal = 0;
        endcase
        if (!legal || addr >= 32'(LIMIT)) begin err = 1'b1; return; end
`ifdef MISALIGN_TRAP_EN
        if (int'(addr % 32'(n)) != 0) begin err = 1'b1; return; end
`endif
        base = int'(addr) - int'(addr % 32'(n));
        if (we) begin
            for (int b = 0; b < n; b++) mb[s][base + b] = wdata[8*b +: 8];
        end else begin
            v = '0;
            for (int b = 0; b < n; b++) v = v | (32'(mb[s][base + b]) << (8 * b));
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rdata = v;
        end
    endtask

    // One complete transaction on DUT s, called at a negedge; hold = cycles of rsp backpressure.
    task automatic applyStimulus(input int s, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] size, input int hold);
        logic [31:0] exp_d, held_d;
        logic        exp_e;
        int          n, lat;
        modelAccess(s, we, addr, wdata, size, exp_d, exp_e);
        sel = s;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        n = 0;
        #1;
        while (!cur_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!cur_req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom); req_we = 1'($urandom);
        lat = 1;
        while (!cur_rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        checkOutput("latency", 32'(lat), 32'(lat_of(s) + 2));
        if (!cur_rsp_valid) return;
        checkOutput("rdata", cur_rsp_rdata, exp_d);
        checkOutput("err", 32'(cur_rsp_err), 32'(exp_e));
        checkOutput("ready_busy", 32'(cur_req_ready), 32'd0);
        last_rdata = cur_rsp_rdata;
        last_err   = cur_rsp_err;
        held_d     = cur_rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            checkOutput("hold_valid", 32'(cur_rsp_valid), 32'd1);
            checkOutput("hold_rdata", cur_rsp_rdata, held_d);
            checkOutput("hold_ready", 32'(cur_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_drop", 32'(cur_rsp_valid), 32'd0);
        checkOutput("ready_back", 32'(cur_req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d, lh30, prev40;
        logic        e;
        int          n, cyc, n_acc, last_acc;
        bit          saw_valid;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checkOutput("rst_req_ready", 32'(cur_req_ready), 32'd1);
            checkOutput("rst_rsp_valid", 32'(cur_rsp_valid), 32'd0);
            checkOutput("rst_rsp_rdata", cur_rsp_rdata, 32'd0);
            checkOutput("rst_rsp_err", 32'(cur_rsp_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 3; s++)
            for (int w = 0; w < DEPTH; w++)
                applyStimulus(s, 1'b1, 32'(w * 4), $urandom, SZ_W, 0);

        applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF, SZ_W, 0);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, SZ_W, 0);
        checkOutput("basic_lw", last_rdata, 32'hDEADBEEF);

        applyStimulus(1, 1'b1, 32'h20, 32'h11223344, SZ_W, 0);
        applyStimulus(1, 1'b1, 32'h21, 32'h000000AA, SZ_B, 0);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, SZ_W, 0);
        checkOutput("lane_lw", last_rdata, 32'h1122AA44);
        applyStimulus(1, 1'b0, 32'h21, 32'h0, SZ_B, 0);
        checkOutput("lane_lb", last_rdata, 32'hFFFFFFAA);
        applyStimulus(1, 1'b0, 32'h21, 32'h0, SZ_BU, 0);
        checkOutput("lane_lbu", last_rdata, 32'h000000AA);
        applyStimulus(1, 1'b0, 32'h22, 32'h0, SZ_HU, 0);
        checkOutput("lane_lhu", last_rdata, 32'h00001122);

        applyStimulus(1, 1'b0, 32'h20, 32'h0, SZ_W, 5);

        applyStimulus(1, 1'b0, 32'(LIMIT), 32'h0, SZ_W, 0);
        checkOutput("range_err", 32'(last_err), 32'd1);
        checkOutput("range_rdata", last_rdata, 32'd0);
        applyStimulus(1, 1'b1, 32'h20, 32'hFFFFFFFF, 3'd3, 0);
        checkOutput("size3_err", 32'(last_err), 32'd1);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, SZ_W, 0);
        checkOutput("size3_nowrite", last_rdata, 32'h1122AA44);
        applyStimulus(1, 1'b1, 32'h30, 32'h8765C321, SZ_W, 0);
        applyStimulus(1, 1'b0, 32'h30, 32'h0, SZ_H, 0);
        lh30 = last_rdata;
        applyStimulus(1, 1'b0, 32'h31, 32'h0, SZ_H, 0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("lh31_err", 32'(last_err), 32'd1);
`else
        checkOutput("lh31_err", 32'(last_err), 32'd0);
        checkOutput("lh31_eq_lh30", last_rdata, lh30);
`endif

        // Store discarded by a reset that lands during WAIT.
        modelAccess(2, 1'b0, 32'h40, 32'h0, SZ_W, prev40, e);
        sel = 2;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_size = SZ_W;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(cur_req_ready), 32'd1);
        checkOutput("midrst_valid", 32'(cur_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_valid = 0;
        repeat (8) begin @(negedge clk); if (cur_rsp_valid) saw_valid = 1; end
        checkOutput("midrst_no_rsp", 32'(saw_valid), 32'd0);
        applyStimulus(2, 1'b0, 32'h40, 32'h0, SZ_W, 0);
        checkOutput("midrst_prior", last_rdata, prev40);

        // Store already performed in ACCESS survives a reset during RESP.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'hCAFEF00D; req_size = SZ_W;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!cur_rsp_valid && n < 40) begin @(negedge clk); n++; end
        rst = 1'b0;
        #1;
        checkOutput("rsprst_valid", 32'(cur_rsp_valid), 32'd0);
        modelAccess(2, 1'b1, 32'h44, 32'hCAFEF00D, SZ_W, d, e);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(2, 1'b0, 32'h44, 32'h0, SZ_W, 0);
        checkOutput("rsprst_persist", last_rdata, 32'hCAFEF00D);

        // LATENCY=0 back-to-back loads with the response always accepted.
        sel = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_size = SZ_W; rsp_ready = 1'b1;
        n_acc = 0; last_acc = -1;
        for (cyc = 0; cyc < 13; cyc++) begin
            #1;
            if (cur_req_ready) begin
                if (last_acc >= 0) checkOutput("b2b_spacing", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("b2b_accepts", 32'(n_acc >= 4), 32'd1);

        for (int i = 0; i < 300; i++) begin
            int s, r;
            logic [31:0] a;
            s = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, LIMIT - 1));
            else if (r == 8) a = 32'(LIMIT - 4 + $urandom_range(0, 11));
            else             a = $urandom;
            applyStimulus(s, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
